tdc_pulse_counter: RTL and testbench
====================================

TDC_PULSE_COUNTER -- requirements
Module: tdc_pulse_counter

Interface
REQ-001 Parameter COUNT_WIDTH, default 16, SHALL set the width of the edge count result.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, SHALL set the depth of the i_pulse synchronizer.
REQ-003 i_clk  input  1  SHALL be the single block clock; all state SHALL update on its rising edge.
REQ-004 i_nreset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_start  input  1  SHALL request a measurement, sampled synchronously.
REQ-006 i_stop  input  1  SHALL end the measurement, sampled synchronously.
REQ-007 i_pulse  input  1  SHALL carry the ring oscillator output; it is asynchronous to i_clk.
REQ-008 o_osc_nreset  output  1  SHALL drive the ring oscillator's active-low reset.
REQ-009 o_osc_start  output  1  SHALL drive the ring oscillator's start input, whose rising edge enables it.
REQ-010 o_count  output  COUNT_WIDTH  SHALL carry the measured rising-edge count.
REQ-011 o_overflow  output  1  SHALL flag that the count saturated.
REQ-012 o_valid  output  1  SHALL mark o_count and o_overflow as valid.
REQ-013 i_ready  input  1  SHALL accept the result.
REQ-014 o_busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 States: IDLE, ARM, RUN, DONE; o_osc_nreset, o_osc_start and o_valid SHALL be registered, glitch-free state decodes.
REQ-016 IDLE: o_osc_nreset=0, o_osc_start=0, o_valid=0; i_start=1 -> ARM, clearing the count to 0 and o_overflow to 0.
REQ-017 ARM: lasts exactly 1 cycle; o_osc_nreset=1, o_osc_start=0; unconditional transition to RUN.
REQ-018 RUN: o_osc_nreset=1, o_osc_start=1, so o_osc_nreset rises exactly one cycle before o_osc_start.
REQ-019 i_pulse SHALL pass through SYNC_STAGES flops; an edge detector SHALL compare the last stage with a history flop that updates every cycle in every state.
REQ-020 Edges are counted only in RUN: each detected rising edge SHALL increment the count by 1, so at most one edge is counted per i_clk cycle.
REQ-021 Oscillator frequency above i_clk/2 is outside the operating range; the block makes no accuracy guarantee there.
REQ-022 The count SHALL saturate at 2^COUNT_WIDTH-1. An edge arriving while the count is saturated SHALL set o_overflow=1, which stays set until the next ARM.
REQ-023 i_stop=1 in RUN -> DONE on the next edge. An edge detected in the same cycle as i_stop SHALL be counted; edges still inside the synchronizer SHALL be discarded.
REQ-024 Latency: i_stop sampled at cycle N SHALL give o_valid=1 at cycle N+1.
REQ-025 DONE: o_osc_nreset=0, o_osc_start=0, o_valid=1; o_count and o_overflow SHALL be held stable.
REQ-026 DONE with o_valid=1 and i_ready=1 SHALL go to IDLE; o_valid SHALL drop in the following cycle.
REQ-027 i_start outside IDLE and i_stop outside RUN SHALL be ignored.
REQ-028 If i_start and i_stop are both high in IDLE, start SHALL win and stop SHALL be ignored.
REQ-029 o_count SHALL keep its last value in IDLE until the next ARM clears it.

Reset
REQ-030 i_nreset=0 SHALL asynchronously force: state=IDLE, o_osc_nreset=0, o_osc_start=0, o_count=0, o_overflow=0, o_valid=0, and all synchronizer and history flops to 0.
REQ-031 Reset asserted mid-RUN or mid-DONE SHALL abort the measurement immediately, with no o_valid pulse.
REQ-032 After i_nreset deasserts, the first i_start SHALL be accepted on the first rising i_clk.

Verification
REQ-033 Basic count: reset, then i_start; 5 i_pulse rising edges spaced 4 clk apart; i_stop 4 clk after the last edge -> o_count=5, o_overflow=0, o_valid=1 one cycle after i_stop.
REQ-034 Saturation: COUNT_WIDTH=4, 20 edges in RUN, then i_stop -> o_count=15, o_overflow=1.
REQ-035 Zero count: i_stop in the first RUN cycle with no edges -> o_count=0, o_valid=1 one cycle later.
REQ-036 Backpressure: i_ready=0 for 10 cycles in DONE, with i_start pulsed meanwhile -> o_valid, o_count and o_busy all stay stable, and the i_start is ignored. Then i_ready=1 -> IDLE on the next edge, o_valid=0 after it.
REQ-037 Sequencing: check o_osc_nreset 0->1 at ARM, o_osc_start 0->1 exactly one cycle later, and both go to 0 on entry to DONE.
REQ-038 Abort: assert i_nreset=0 mid-RUN between clock edges -> all outputs take their reset values immediately, including o_osc_nreset=0, with no o_valid afterwards.

Source files
------------

// File: rtl/tdc_pulse_counter.sv
// tdc_pulse_counter: gates a ring oscillator on and off and counts its rising
// edges between a start request and a stop request.
//
// Handshake: o_valid is held high in DONE together with stable o_count and
// o_overflow. The result is consumed on a rising i_clk edge where
// o_valid && i_ready. o_valid drops in the cycle after that edge. o_valid does
// not depend on i_ready.
//
// i_pulse is asynchronous. It passes through SYNC_STAGES flops (minimum 2).
// A history flop then tracks the last stage every cycle, so edge detection is
// always primed with the oscillator's real level. The oscillator is reset
// outside ARM/RUN, so that level is normally low.
module tdc_pulse_counter #(
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_nreset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_pulse,
  input  logic                   i_ready,
  output logic                   o_osc_nreset,
  output logic                   o_osc_start,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_overflow,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   pulse_edge;

  // Synchronizer chain plus history flop; both run in every state.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pulse};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Measurement FSM.
  // The oscillator controls and o_valid are registered from the next state.
  // This keeps them glitch-free and aligned with the state register.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state        <= S_IDLE;
      o_osc_nreset <= 1'b0;
      o_osc_start  <= 1'b0;
      o_count      <= '0;
      o_overflow   <= 1'b0;
      o_valid      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Start wins over a simultaneous stop; stop alone is ignored here.
          if (i_start) begin
            state        <= S_ARM;
            o_osc_nreset <= 1'b1;
            o_osc_start  <= 1'b0;
            o_count      <= '0;
            o_overflow   <= 1'b0;
          end
        end
        S_ARM: begin
          // Oscillator leaves reset one cycle before it is enabled.
          state       <= S_RUN;
          o_osc_start <= 1'b1;
        end
        S_RUN: begin
          // The edge seen in the same cycle as i_stop is still counted.
          if (pulse_edge) begin
            if (o_count == COUNT_MAX) begin
              o_overflow <= 1'b1;
            end else begin
              o_count <= o_count + 1'b1;
            end
          end
          // Edges still inside the synchronizer are dropped once RUN ends.
          if (i_stop) begin
            state        <= S_DONE;
            o_osc_nreset <= 1'b0;
            o_osc_start  <= 1'b0;
            o_valid      <= 1'b1;
          end
        end
        S_DONE: begin
          // Hold the result until it is accepted; i_start is ignored here.
          if (i_ready) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          o_osc_nreset <= 1'b0;
          o_osc_start  <= 1'b0;
          o_valid      <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = (state != S_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_tdc_pulse_counter.sv
// tb_tdc_pulse_counter: directed test of tdc_pulse_counter with COUNT_WIDTH=4.
// The narrow count lets the design reach saturation with a few edges.
module tb_tdc_pulse_counter;

  localparam int CW = 4;

  logic          clk;
  logic          nreset;
  logic          start;
  logic          stop;
  logic          pulse;
  logic          ready;
  logic          osc_nreset;
  logic          osc_start;
  logic [CW-1:0] count;
  logic          overflow;
  logic          valid;
  logic          busy;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_err = 0;

  tdc_pulse_counter #(.COUNT_WIDTH(CW), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_nreset     (nreset),
    .i_start      (start),
    .i_stop       (stop),
    .i_pulse      (pulse),
    .i_ready      (ready),
    .o_osc_nreset (osc_nreset),
    .o_osc_start  (osc_start),
    .o_count      (count),
    .o_overflow   (overflow),
    .o_valid      (valid),
    .o_busy       (busy),
    .o_state      (state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One oscillator rising edge, high for hi cycles, low for lo cycles.
  task automatic osc_edge(input int hi, input int lo);
    pulse = 1'b1;
    tick(hi);
    pulse = 1'b0;
    tick(lo);
  endtask

  initial begin
    nreset = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    pulse  = 1'b0;
    ready  = 1'b0;
    #23;
    // Reset values.
    check("rst_state", state, 0);
    check("rst_osc_nreset", osc_nreset, 0);
    check("rst_osc_start", osc_start, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    nreset = 1'b1;
    tick();

    // Sequencing and basic count.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arm_state", state, 1);
    check("arm_osc_nreset", osc_nreset, 1);
    check("arm_osc_start", osc_start, 0);
    check("arm_busy", busy, 1);
    tick();
    check("run_state", state, 2);
    check("run_osc_nreset", osc_nreset, 1);
    check("run_osc_start", osc_start, 1);
    for (int e = 0; e < 5; e++) osc_edge(2, 2);
    tick(4);
    check("run_count5", count, 5);
    check("run_valid", valid, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("done_valid", valid, 1);
    check("done_count", count, 5);
    check("done_overflow", overflow, 0);
    check("done_osc_nreset", osc_nreset, 0);
    check("done_osc_start", osc_start, 0);
    check("done_state", state, 3);

    // Backpressure: result held, i_start ignored.
    for (int c = 0; c < 10; c++) begin
      start = (c % 3 == 1);
      tick();
      check("bp_valid", valid, 1);
      check("bp_count", count, 5);
      check("bp_busy", busy, 1);
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("acc_state", state, 0);
    check("acc_valid", valid, 0);
    check("acc_busy", busy, 0);
    check("idle_hold_count", count, 5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle_stop_ignored", state, 0);

    // Zero count: stop in the first RUN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_arm_clear", count, 0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("zero_valid", valid, 1);
    check("zero_count", count, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Saturation: 20 edges at the fastest in-range rate.
    start = 1'b1;
    tick(2);
    start = 1'b0;
    for (int e = 0; e < 20; e++) osc_edge(1, 1);
    tick(3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sat_count", count, 15);
    check("sat_overflow", overflow, 1);
    check("sat_valid", valid, 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("sat_idle_overflow", overflow, 1);

    // Start and stop together in IDLE: start wins and clears the result.
    // A stop held through ARM is ignored.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    check("ss_state", state, 1);
    check("ss_count_clr", count, 0);
    check("ss_overflow_clr", overflow, 0);
    tick();
    stop = 1'b0;
    check("arm_stop_ignored", state, 2);

    // An edge detected in the same cycle as stop is counted.
    pulse = 1'b1;
    tick(2);
    stop = 1'b1;
    tick();
    stop  = 1'b0;
    pulse = 1'b0;
    check("edge_at_stop", count, 1);
    check("edge_at_stop_state", state, 3);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // An edge still in the synchronizer at stop is discarded.
    start = 1'b1;
    tick(2);
    start = 1'b0;
    pulse = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(3);
    pulse = 1'b0;
    check("sync_discard", count, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Abort mid-RUN between clock edges.
    start = 1'b1;
    tick(2);
    start = 1'b0;
    osc_edge(2, 2);
    tick(2);
    check("abort_pre_count", count, 1);
    #2;
    nreset = 1'b0;
    #1;
    check("abort_state", state, 0);
    check("abort_osc_nreset", osc_nreset, 0);
    check("abort_osc_start", osc_start, 0);
    check("abort_count", count, 0);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    tick(2);
    check("abort_hold_valid", valid, 0);
    // The first rising edge after reset release accepts i_start.
    start = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_start", state, 1);
    tick(2);
    check("post_rst_no_valid", valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
